// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP multiplier.
// The slave side (the multiplier) takes operands and produces results.
interface fp_mul_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754-style multiplier: unpack/classify, mantissa product,
// normalise/round-nearest-even/pack. Subnormal inputs are treated as zero.
module fp_mul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    fp_mul_pipe_if.slave       bus
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned MW1  = MAN_W + 1;
    localparam int unsigned PW   = 2 * MAN_W + 2;
    localparam int unsigned BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (2 ** EXP_W) - 1;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Stage registers
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q, s1_sign_d;
    logic signed [EW-1:0]  s1_exp_q, s1_exp_d;
    logic [MW1-1:0]        s1_man_a_q, s1_man_a_d;
    logic [MW1-1:0]        s1_man_b_q, s1_man_b_d;
    logic                  s1_spec_q, s1_spec_d;
    logic                  s1_inv_q, s1_inv_d;
    logic [W-1:0]          s1_spec_data_q, s1_spec_data_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q, s2_sign_d;
    logic signed [EW-1:0]  s2_exp_q, s2_exp_d;
    logic [PW-1:0]         s2_prod_q, s2_prod_d;
    logic                  s2_spec_q, s2_spec_d;
    logic                  s2_inv_q, s2_inv_d;
    logic [W-1:0]          s2_spec_data_q, s2_spec_data_d;

    logic                  out_valid_q, out_valid_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic [3:0]            out_flags_q, out_flags_d;

    logic adv;

    // Operand decode
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_man, b_man;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               sign_ab;

    assign a_sign = bus.in_a[W-1];
    assign b_sign = bus.in_b[W-1];
    assign a_exp  = bus.in_a[W-2 -: EXP_W];
    assign b_exp  = bus.in_b[W-2 -: EXP_W];
    assign a_man  = bus.in_a[MAN_W-1:0];
    assign b_man  = bus.in_b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == '1) && (a_man == '0);
    assign b_inf  = (b_exp == '1) && (b_man == '0);
    assign a_nan  = (a_exp == '1) && (a_man != '0);
    assign b_nan  = (b_exp == '1) && (b_man != '0);
    assign sign_ab = a_sign ^ b_sign;

    // Normalise and round the stage-2 product
    logic [PW-2:0]         norm;
    logic signed [EW-1:0]  e_norm, e_rnd;
    logic [MAN_W-1:0]      man_t;
    logic                  guard, sticky, round_up;
    logic [MW1-1:0]        man_r;

    assign norm     = s2_prod_q[PW-1] ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    assign e_norm   = s2_exp_q + $signed({{(EW-1){1'b0}}, s2_prod_q[PW-1]});
    assign man_t    = norm[PW-2 -: MAN_W];
    assign guard    = norm[PW-2-MAN_W];
    assign sticky   = |norm[PW-3-MAN_W:0];
    assign round_up = guard & (sticky | man_t[0]);
    assign man_r    = {1'b0, man_t} + MW1'(round_up);
    assign e_rnd    = e_norm + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_sign_d      = s1_sign_q;
        s1_exp_d       = s1_exp_q;
        s1_man_a_d     = s1_man_a_q;
        s1_man_b_d     = s1_man_b_q;
        s1_spec_d      = s1_spec_q;
        s1_inv_d       = s1_inv_q;
        s1_spec_data_d = s1_spec_data_q;
        s2_valid_d     = s2_valid_q;
        s2_sign_d      = s2_sign_q;
        s2_exp_d       = s2_exp_q;
        s2_prod_d      = s2_prod_q;
        s2_spec_d      = s2_spec_q;
        s2_inv_d       = s2_inv_q;
        s2_spec_data_d = s2_spec_data_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_flags_d    = out_flags_q;

        if (adv) begin
            // S1: classify and sum exponents
            s1_valid_d     = bus.in_valid;
            s1_sign_d      = sign_ab;
            s1_exp_d       = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(EW'(BIAS));
            s1_man_a_d     = {1'b1, a_man};
            s1_man_b_d     = {1'b1, b_man};
            s1_spec_d      = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
            s1_inv_d       = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
            if (s1_inv_d) begin
                s1_spec_data_d = QNAN;
            end else if (a_inf || b_inf) begin
                s1_spec_data_d = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                s1_spec_data_d = {sign_ab, {(W-1){1'b0}}};
            end

            // S2: mantissa product
            s2_valid_d     = s1_valid_q;
            s2_sign_d      = s1_sign_q;
            s2_exp_d       = s1_exp_q;
            s2_prod_d      = PW'(s1_man_a_q) * PW'(s1_man_b_q);
            s2_spec_d      = s1_spec_q;
            s2_inv_d       = s1_inv_q;
            s2_spec_data_d = s1_spec_data_q;

            // S3: pack result; data/flags only move when a real result lands
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_spec_q) begin
                    out_data_d  = s2_spec_data_q;
                    out_flags_d = {s2_inv_q, 3'b000};
                end else if (e_norm < $signed(EW'(1))) begin
                    out_data_d  = {s2_sign_q, {(W-1){1'b0}}};
                    out_flags_d = 4'b0011;
                end else if (e_rnd >= $signed(EW'(EMAX))) begin
                    out_data_d  = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    out_flags_d = 4'b0101;
                end else begin
                    out_data_d  = {s2_sign_q, e_rnd[EXP_W-1:0], man_r[MAN_W-1:0]};
                    out_flags_d = {3'b000, guard | sticky};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_sign_q      <= 1'b0;
            s1_exp_q       <= '0;
            s1_man_a_q     <= '0;
            s1_man_b_q     <= '0;
            s1_spec_q      <= 1'b0;
            s1_inv_q       <= 1'b0;
            s1_spec_data_q <= '0;
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_exp_q       <= '0;
            s2_prod_q      <= '0;
            s2_spec_q      <= 1'b0;
            s2_inv_q       <= 1'b0;
            s2_spec_data_q <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_flags_q    <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_sign_q      <= s1_sign_d;
            s1_exp_q       <= s1_exp_d;
            s1_man_a_q     <= s1_man_a_d;
            s1_man_b_q     <= s1_man_b_d;
            s1_spec_q      <= s1_spec_d;
            s1_inv_q       <= s1_inv_d;
            s1_spec_data_q <= s1_spec_data_d;
            s2_valid_q     <= s2_valid_d;
            s2_sign_q      <= s2_sign_d;
            s2_exp_q       <= s2_exp_d;
            s2_prod_q      <= s2_prod_d;
            s2_spec_q      <= s2_spec_d;
            s2_inv_q       <= s2_inv_d;
            s2_spec_data_q <= s2_spec_data_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_flags_q    <= out_flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;
endmodule
